// File: rtl/register_file_1w_multi_port_read_be_pkg.sv
// Shared helpers for the wide-write / narrow-read register file.
package regfile_pkg;

  localparam int unsigned BYTE_W = 8;

  // Width of a select signal for n choices; never 0 so a single-choice
  // select still has a legal (1-bit) declaration.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Lane field of a read address: the low lane_w bits, or 0 when a row
  // holds a single lane.
  function automatic int unsigned lane_extract(input int unsigned addr,
                                               input int unsigned lane_w);
    return (lane_w == 0) ? 0 : (addr & ((32'd1 << lane_w) - 32'd1));
  endfunction

endpackage

// File: rtl/register_file_1w_multi_port_read_be_bank.sv
// One lane bank: rows of DATA_W bits, byte-enabled write, one registered
// read port. Reads return the pre-write contents on a same-row collision.
module scm_bank_1r_1w_be
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8,
  localparam int N_ROWS = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [BE_W-1:0]   wbe_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [N_ROWS];
  logic [DATA_W-1:0] rdata_q;

  // Storage: byte-granular write, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wbe_i[b]) mem_q[waddr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read register: loads only on a read, so it holds while the port idles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/register_file_1w_multi_port_read_be.sv
// One wide byte-enabled write port, N_READ narrow read ports, 1-cycle read
// latency, optional same-cycle write-to-read bypass, output hold on idle.
module register_file_1w_multi_port_read_be
  import regfile_pkg::*;
#(
  parameter int WADDR_WIDTH = 5,
  parameter int WDATA_WIDTH = 64,
  parameter int RDATA_WIDTH = 32,
  parameter int N_READ      = 4,
  parameter int BYPASS      = 1,
  localparam int RATIO       = WDATA_WIDTH / RDATA_WIDTH,
  localparam int LANE_W      = $clog2(RATIO),
  localparam int RADDR_WIDTH = WADDR_WIDTH + LANE_W,
  localparam int W_N_ROWS    = 2 ** WADDR_WIDTH
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_READ-1:0]                     ReadEnable,
  input  logic [N_READ-1:0][RADDR_WIDTH-1:0]    ReadAddr,
  output logic [N_READ-1:0][RDATA_WIDTH-1:0]    ReadData,
  output logic [N_READ-1:0]                     ReadValid,
  input  logic                                  WriteEnable,
  input  logic [WADDR_WIDTH-1:0]                WriteAddr,
  input  logic [WDATA_WIDTH/8-1:0]              WriteBE,
  input  logic [WDATA_WIDTH-1:0]                WriteData
);

  localparam int LANE_SW = clog2_min1(RATIO);
  localparam int BW      = RDATA_WIDTH / 8;

  // Parameter legality, caught at elaboration.
  if (WDATA_WIDTH % RDATA_WIDTH != 0 || RATIO < 1 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("WDATA_WIDTH/RDATA_WIDTH must be a power-of-two integer ratio");
  end
  if (RDATA_WIDTH % 8 != 0) begin : g_bad_rdata
    $error("RDATA_WIDTH must be a multiple of 8");
  end
  if (N_READ < 1) begin : g_bad_nread
    $error("N_READ must be at least 1");
  end
  if (W_N_ROWS < 2) begin : g_bad_rows
    $error("WADDR_WIDTH must be at least 1");
  end

  // Lane views of the write port; lane 0 is the least significant slice.
  logic [RATIO-1:0][RDATA_WIDTH-1:0] wdata_lanes;
  logic [RATIO-1:0][BW-1:0]          wbe_lanes;

  assign wdata_lanes = WriteData;
  assign wbe_lanes   = WriteBE;

  logic [N_READ-1:0][RATIO-1:0][RDATA_WIDTH-1:0] bank_rdata;

  for (genvar i = 0; i < N_READ; i++) begin : g_port
    logic [WADDR_WIDTH-1:0] rd_row;
    logic [LANE_SW-1:0]     rd_lane;
    logic                   hit;

    logic                   vld_q;
    logic [LANE_SW-1:0]     lane_q;
    logic                   byp_q;
    logic [RDATA_WIDTH-1:0] byp_data_q;
    logic [BW-1:0]          byp_be_q;

    logic [RDATA_WIDTH-1:0] old_w;
    logic [RDATA_WIDTH-1:0] merged;

    assign rd_row  = ReadAddr[i][RADDR_WIDTH-1:LANE_W];
    assign rd_lane = LANE_SW'(lane_extract(32'(ReadAddr[i]), LANE_W));

    // Same-row write in the read cycle; only matters when bypassing.
    assign hit = (BYPASS != 0) && WriteEnable && (WriteAddr == rd_row);

    // Each port owns a private copy of every lane bank so every bank stays
    // one-read/one-write. Only the addressed lane's bank is read; the
    // others keep their old value, which the lane mux never selects.
    for (genvar l = 0; l < RATIO; l++) begin : g_lane
      logic re_lane;
      assign re_lane = ReadEnable[i] && (rd_lane == LANE_SW'(l));

      scm_bank_1r_1w_be #(
        .ADDR_W (WADDR_WIDTH),
        .DATA_W (RDATA_WIDTH)
      ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (WriteEnable),
        .waddr_i (WriteAddr),
        .wbe_i   (wbe_lanes[l]),
        .wdata_i (wdata_lanes[l]),
        .re_i    (re_lane),
        .raddr_i (rd_row),
        .rdata_o (bank_rdata[i][l])
      );
    end

    // Per-port read context: valid pulse, lane select and bypass bytes are
    // captured with the read and held while the port idles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q      <= 1'b0;
        lane_q     <= '0;
        byp_q      <= 1'b0;
        byp_data_q <= '0;
        byp_be_q   <= '0;
      end else begin
        vld_q <= ReadEnable[i];
        if (ReadEnable[i]) begin
          lane_q     <= rd_lane;
          byp_q      <= hit;
          byp_data_q <= wdata_lanes[rd_lane];
          byp_be_q   <= wbe_lanes[rd_lane];
        end
      end
    end

    assign old_w = bank_rdata[i][lane_q];

    // Overlay the bytes written in the read cycle onto the old lane data.
    always_comb begin
      merged = old_w;
      for (int b = 0; b < BW; b++) begin
        if (byp_q && byp_be_q[b]) merged[b*BYTE_W +: BYTE_W] = byp_data_q[b*BYTE_W +: BYTE_W];
      end
    end

    assign ReadData[i]  = merged;
    assign ReadValid[i] = vld_q;
  end

endmodule
